// File: rtl/game_sequencer.sv
// Turn-and-move sequencer for the 16x16 five-in-a-row board.
// States: IDLE wait for buttons | PROBE read target cell | WRITE strobe stone | SETTLE let checker settle | EVAL win/draw/pass | OVER frozen until reset
module game_sequencer #(
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int TIMER_W        = 29,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_put,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic [1:0] cell_state,
    input  logic [1:0] check_ans,
    output logic [7:0] cursor,
    output logic       wr_en,
    output logic [1:0] wr_color,
    output logic [1:0] turn,
    output logic [8:0] move_count,
    output logic       busy,
    output logic       reject,
    output logic       timeout,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw
);

    typedef enum logic [2:0] {
        S_IDLE, S_PROBE, S_WRITE, S_SETTLE, S_EVAL, S_OVER
    } state_t;

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam bit                 TIMEOUT_EN  = (TIMEOUT_CYCLES > 0);
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [SET_W-1:0]   settle_cnt;
    logic               put_prev, right_prev, down_prev;
    logic               put_edge, right_edge, down_edge;

    assign put_edge   = btn_put   & ~put_prev;
    assign right_edge = btn_right & ~right_prev;
    assign down_edge  = btn_down  & ~down_prev;

    always_ff @(posedge clock) begin
        // prev tracks the level even in reset so a held button never fires
        put_prev   <= btn_put;
        right_prev <= btn_right;
        down_prev  <= btn_down;
        if (reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            settle_cnt <= '0;
            cursor     <= 8'h00;
            wr_en      <= 1'b0;
            wr_color   <= 2'b00;
            turn       <= 2'b01;
            move_count <= 9'd0;
            busy       <= 1'b0;
            reject     <= 1'b0;
            timeout    <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            draw       <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            wr_color <= 2'b00;
            reject   <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (put_edge) begin
                        state <= S_PROBE;
                        busy  <= 1'b1;
                        timer <= '0;
                    end else begin
                        if (right_edge) cursor[3:0] <= cursor[3:0] + 4'd1;
                        if (down_edge)  cursor[7:4] <= cursor[7:4] + 4'd1;
                        if (TIMEOUT_EN) begin
                            if (timer == TIMER_LAST) begin
                                turn    <= ~turn;
                                timer   <= '0;
                                timeout <= 1'b1;
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end
                end
                S_PROBE: begin
                    if (cell_state != 2'b00) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        reject <= 1'b1;
                    end else begin
                        state      <= S_WRITE;
                        wr_en      <= 1'b1;
                        wr_color   <= turn;
                        move_count <= move_count + 9'd1;
                    end
                end
                S_WRITE: begin
                    state      <= S_SETTLE;
                    settle_cnt <= SETTLE_LAST;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) state <= S_EVAL;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                S_EVAL: begin
                    busy <= 1'b0;
                    if (check_ans == 2'b01 || check_ans == 2'b10) begin
                        state     <= S_OVER;
                        winner    <= check_ans;
                        game_over <= 1'b1;
                    end else if (move_count == 9'd256) begin
                        state     <= S_OVER;
                        draw      <= 1'b1;
                        game_over <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        turn  <= ~turn;
                        timer <= '0;
                    end
                end
                S_OVER: begin
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
